// File: rtl/sb_rx_framer_if.sv
// sb_rx_framer_if: line input, enable and deframed byte/frame outputs of the sideband receiver.
// The master side drives the line; the slave side is the framer.
interface sb_rx_framer_if;
   logic       rx_en;
   logic       sbrx;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_sof;
   logic       frame_done;
   logic [6:0] frame_len;
   logic       frame_err;
   modport master (output rx_en, sbrx, input rx_data, rx_valid, rx_sof, frame_done, frame_len, frame_err);
   modport slave (input rx_en, sbrx, output rx_data, rx_valid, rx_sof, frame_done, frame_len, frame_err);
endinterface

// File: rtl/sb_rx_framer.sv
// sb_rx_framer: sideband UART character recovery and DLE/STX..DLE/ETX deframing with de-stuffing.
// Defining SB_RX_STATS_EN adds saturating frame/error counters cleared by stat_clr.
module sb_rx_framer #(
   parameter int         SYNC_STAGES = 2,
   parameter int         MAX_LEN     = 64,
   parameter logic [7:0] DLE         = 8'hFE,
   parameter logic [7:0] STX         = 8'h05,
   parameter logic [7:0] ETX         = 8'h40
) (
   input  logic        sb_clk,
   input  logic        rst,
`ifdef SB_RX_STATS_EN
   input  logic        stat_clr,
   output logic [15:0] stat_frames,
   output logic [15:0] stat_errs,
`endif
   sb_rx_framer_if.slave sb
);
   typedef enum logic [1:0] {C_IDLE, C_DATA, C_STOP, C_BRK} c_state_t;
   typedef enum logic [1:0] {F_IDLE, F_HDR, F_PAY, F_ESC} f_state_t;
   localparam logic [6:0] MAX_LEN7 = 7'(MAX_LEN);
   logic [SYNC_STAGES-1:0] sync;
   logic                   s;
   c_state_t               c_state;
   f_state_t               f_state;
   logic [2:0]             bit_cnt;
   logic [7:0]             ch;
   logic                   sof;
   logic [6:0]             len;
   logic                   char_stb, stop_err, emit;
   logic [7:0]             rx_data;
   logic                   rx_valid, rx_sof, frame_done, frame_err;
   logic [6:0]             frame_len;
   assign s        = sync[SYNC_STAGES-1];
   assign char_stb = sb.rx_en && c_state == C_STOP && s;
   assign stop_err = sb.rx_en && c_state == C_STOP && !s;
   assign emit     = char_stb && ((f_state == F_PAY && ch != DLE) || (f_state == F_ESC && ch == DLE));
   always_ff @(posedge sb_clk or posedge rst)
      if (rst) begin
         sync    <= '1;
         c_state <= C_IDLE;
         bit_cnt <= '0;
         ch      <= '0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], sb.sbrx};
         if (!sb.rx_en) c_state <= C_IDLE;
         else case (c_state)
            C_IDLE: if (!s) begin
               c_state <= C_DATA;
               bit_cnt <= '0;
            end
            C_DATA: begin
               ch      <= {s, ch[7:1]};
               bit_cnt <= bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) c_state <= C_STOP;
            end
            C_STOP: c_state <= s ? C_IDLE : C_BRK;
            default: if (s) c_state <= C_IDLE;
         endcase
      end
   // Outputs are registered on the char_stb edge, so they appear one cycle after the stop-bit sample.
   always_ff @(posedge sb_clk or posedge rst)
      if (rst) begin
         f_state    <= F_IDLE;
         sof        <= 1'b0;
         len        <= '0;
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         rx_sof     <= 1'b0;
         frame_done <= 1'b0;
         frame_len  <= '0;
         frame_err  <= 1'b0;
      end else begin
         rx_valid   <= 1'b0;
         rx_sof     <= 1'b0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         if (!sb.rx_en) f_state <= F_IDLE;
         else if (stop_err) begin
            frame_err <= 1'b1;
            f_state   <= F_IDLE;
         end else if (emit) begin
            if (len == MAX_LEN7) begin
               frame_err <= 1'b1;
               f_state   <= F_IDLE;
            end else begin
               rx_valid <= 1'b1;
               rx_data  <= ch;
               rx_sof   <= sof;
               sof      <= 1'b0;
               len      <= len + 7'd1;
               f_state  <= F_PAY;
            end
         end else if (char_stb) case (f_state)
            F_IDLE: if (ch == DLE) f_state <= F_HDR;
            F_HDR: if (ch == STX) begin
               f_state <= F_PAY;
               sof     <= 1'b1;
               len     <= '0;
            end else if (ch != DLE) f_state <= F_IDLE;
            F_PAY: f_state <= F_ESC;
            default: if (ch == ETX) begin
               frame_done <= 1'b1;
               frame_len  <= len;
               f_state    <= F_IDLE;
            end else if (ch == STX) begin
               frame_err <= 1'b1;
               f_state   <= F_PAY;
               sof       <= 1'b1;
               len       <= '0;
            end else begin
               frame_err <= 1'b1;
               f_state   <= F_IDLE;
            end
         endcase
      end
   assign sb.rx_data    = rx_data;
   assign sb.rx_valid   = rx_valid;
   assign sb.rx_sof     = rx_sof;
   assign sb.frame_done = frame_done;
   assign sb.frame_len  = frame_len;
   assign sb.frame_err  = frame_err;
`ifdef SB_RX_STATS_EN
   always_ff @(posedge sb_clk or posedge rst)
      if (rst || stat_clr) begin
         stat_frames <= '0;
         stat_errs   <= '0;
      end else begin
         if (frame_done && stat_frames != 16'hFFFF) stat_frames <= stat_frames + 16'd1;
         if (frame_err && stat_errs != 16'hFFFF) stat_errs <= stat_errs + 16'd1;
      end
`endif
endmodule
